// File: rtl/pix_shifter_pkg.sv
// Shared types and defaults for the pix_shifter planar pixel serializer.
package pix_shifter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } shiftState_e;

  localparam int DEFAULT_PLANES = 2;
  localparam int DEFAULT_WIDTH  = 8;

  // Lowest bit of bitplane 'plane' inside a packed planar word.
  function automatic int planeLsb(input int plane, input int width);
    return plane * width;
  endfunction

endpackage

// File: rtl/pix_plane_sr.sv
// One bitplane load-and-shift register (LS194-style): parallel load wins over
// shift, flip selects which end feeds the output and the shift direction.
module pix_plane_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadData_i,
  input  logic             shift_i,
  input  logic             flip_i,
  output logic             outBit_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Data always moves toward the output end with zero fill behind it.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = loadData_i;
    end else if (shift_i) begin
      data_d = flip_i ? {1'b0, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign outBit_o = flip_i ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/pix_shifter.sv
// Planar pixel serializer: one-deep holding latch feeding PLANES shift registers.
// Optional PIX_SHIFTER_BLANK_EN adds blank_i, which zeroes the registered pixel output.
module pix_shifter
  import pix_shifter_pkg::*;
#(
  parameter int PLANES = DEFAULT_PLANES,
  parameter int WIDTH  = DEFAULT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
`ifdef PIX_SHIFTER_BLANK_EN
  input  logic                    blank_i,
`endif
  input  logic                    pixen_i,
  input  logic [PLANES*WIDTH-1:0] din_i,
  input  logic                    dflip_i,
  input  logic                    dvalid_i,
  output logic                    dready_o,
  output logic [PLANES-1:0]       pix_o,
  output logic                    pixvalid_o,
  output logic                    underrun_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  shiftState_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    flip_q, flip_d;
  logic                    holdValid_q, holdValid_d;
  logic [PLANES*WIDTH-1:0] holdData_q, holdData_d;
  logic                    holdFlip_q, holdFlip_d;
  logic                    readyEn_q;
  logic [PLANES-1:0]       pix_q, pix_d;
  logic                    pixValid_q, pixValid_d;
  logic                    underrun_q, underrun_d;
  logic                    loadSr;
  logic                    shiftSr;
  logic                    accept;
  logic [PLANES-1:0]       planeBit;

  // readyEn_q keeps dready low until the first edge after reset release.
  assign dready_o = readyEn_q & ~holdValid_q;
  assign accept   = dvalid_i & dready_o;

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    pix_plane_sr #(.WIDTH(WIDTH)) u_sr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (loadSr),
      .loadData_i (holdData_q[planeLsb(p, WIDTH) +: WIDTH]),
      .shift_i    (shiftSr),
      .flip_i     (flip_q),
      .outBit_o   (planeBit[p])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flip_d      = flip_q;
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    holdFlip_d  = holdFlip_q;
    pix_d       = pix_q;
    pixValid_d  = pixValid_q;
    underrun_d  = 1'b0;
    loadSr      = 1'b0;
    shiftSr     = 1'b0;

    case (state_q)
      EMPTY: begin
        if (pixen_i) begin
          pix_d      = '0;
          pixValid_d = 1'b0;
          underrun_d = 1'b1;
        end
        if (holdValid_q) begin
          loadSr      = 1'b1;
          state_d     = SHIFT;
          cnt_d       = '0;
          flip_d      = holdFlip_q;
          holdValid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (pixen_i) begin
          pix_d      = planeBit;
          pixValid_d = 1'b1;
          shiftSr    = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          // Last pixel: reload from holding in the same edge for a gapless stream.
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (holdValid_q) begin
              loadSr      = 1'b1;
              flip_d      = holdFlip_q;
              holdValid_d = 1'b0;
            end else begin
              state_d = EMPTY;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      holdValid_d = 1'b1;
      holdData_d  = din_i;
      holdFlip_d  = dflip_i;
    end

`ifdef PIX_SHIFTER_BLANK_EN
    if (blank_i) begin
      pix_d      = '0;
      pixValid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      flip_q      <= 1'b0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      holdFlip_q  <= 1'b0;
      readyEn_q   <= 1'b0;
      pix_q       <= '0;
      pixValid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flip_q      <= flip_d;
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      holdFlip_q  <= holdFlip_d;
      readyEn_q   <= 1'b1;
      pix_q       <= pix_d;
      pixValid_q  <= pixValid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pix_o      = pix_q;
  assign pixvalid_o = pixValid_q;
  assign underrun_o = underrun_q;

endmodule
